// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the CDB arbiter and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// tag_t       : ROB tag; the value 0 means "no tag" and is never broadcast.
// cdb_entry_t : one common-data-bus payload {tag, val, is_br, br_pred_res, pc_next}.
package rv32i_types;

    localparam int TAG_W         = 3;
    localparam int DATA_W        = 32;
    localparam int NUM_CDB_PORTS = 2;

    typedef logic [TAG_W-1:0] tag_t;

    typedef struct packed {
        tag_t              tag;
        logic [DATA_W-1:0] val;
        logic              is_br;
        logic              br_pred_res;
        logic [DATA_W-1:0] pc_next;
    } cdb_entry_t;

endpackage

// File: rtl/rr_multi_picker.sv
// Round-robin multi-grant picker: up to NUM_PORTS grants per cycle over a full vector.
// Latency: purely combinational.
// Backpressure: none; only slots marked full can be granted.
//
// Ports:
//   full      in   NUM_REQ             slot i holds a result
//   rr_ptr    in   IDX_W               first index examined in the scan
//   port_oh   out  NUM_PORTS x NUM_REQ one-hot grant for each port
//   port_vld  out  NUM_PORTS           port p received a grant
//   port_idx  out  NUM_PORTS x IDX_W   granted index for port p
//   grant     out  NUM_REQ             union of all port grants
//   any_grant out  1                   at least one grant issued
//   last_idx  out  IDX_W               index of the last grant in scan order
module rr_multi_picker #(
    parameter int  NUM_REQ   = 8,
    parameter int  NUM_PORTS = 2,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   full,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0]   port_oh [NUM_PORTS],
    output logic [NUM_PORTS-1:0] port_vld,
    output logic [IDX_W-1:0]     port_idx [NUM_PORTS],
    output logic [NUM_REQ-1:0]   grant,
    output logic                 any_grant,
    output logic [IDX_W-1:0]     last_idx
);

    // Each port takes the first still-unclaimed full slot in rotation order
    // starting at rr_ptr, so port k always holds the k-th grant of the scan.
    always_comb begin
        logic [NUM_REQ-1:0] remain;
        logic [IDX_W:0]     scan;
        logic [IDX_W-1:0]   idx;
        logic               found;

        remain    = full;
        port_vld  = '0;
        any_grant = 1'b0;
        last_idx  = rr_ptr;
        scan      = '0;
        idx       = '0;
        found     = 1'b0;

        for (int p = 0; p < NUM_PORTS; p++) begin
            port_oh[p]  = '0;
            port_idx[p] = '0;
            found       = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                // Modulo add without a divider: one conditional subtract suffices.
                scan = {1'b0, rr_ptr} + (IDX_W+1)'(j);
                if (scan >= (IDX_W+1)'(NUM_REQ)) begin
                    scan = scan - (IDX_W+1)'(NUM_REQ);
                end
                idx = scan[IDX_W-1:0];
                if (!found && remain[idx]) begin
                    found           = 1'b1;
                    port_oh[p][idx] = 1'b1;
                    port_idx[p]     = idx;
                    remain[idx]     = 1'b0;
                end
            end
            port_vld[p] = found;
            if (found) begin
                last_idx  = port_idx[p];
                any_grant = 1'b1;
            end
        end

        grant = full & ~remain;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares NUM_PORTS CDB broadcast ports among NUM_REQ result sources via one-entry holding slots.
// Latency: 2 edges from source transfer to cdb_valid (slot load, then output register).
// Backpressure: req_ready[i] = slot empty or being granted this cycle; low during rst/flush.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   flush       mispredict flush, same effect as rst on this block
//   req_valid   in   NUM_REQ              source i offers req_data[i]
//   req_ready   out  NUM_REQ              source i's offer is taken at this edge
//   req_data    in   NUM_REQ x cdb_entry_t
//   cdb_valid   out  NUM_PORTS            registered broadcast strobe, one pulse per result
//   cdb_data    out  NUM_PORTS x cdb_entry_t (held when the port is idle)
//   cdb_src     out  NUM_PORTS x SRC_W    source index of each broadcast
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int  NUM_REQ   = 8,
    parameter int  NUM_PORTS = NUM_CDB_PORTS,
    localparam int SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  cdb_entry_t           req_data [NUM_REQ],
    output logic [NUM_PORTS-1:0] cdb_valid,
    output cdb_entry_t           cdb_data [NUM_PORTS],
    output logic [SRC_W-1:0]     cdb_src  [NUM_PORTS]
);

    logic                 clr;
    cdb_entry_t           slot [NUM_REQ];
    logic [NUM_REQ-1:0]   slot_full;
    logic [SRC_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   xfer;

    logic [NUM_REQ-1:0]   port_oh  [NUM_PORTS];
    logic [NUM_PORTS-1:0] port_vld;
    logic [SRC_W-1:0]     port_idx [NUM_PORTS];
    logic [NUM_REQ-1:0]   grant;
    logic                 any_grant;
    logic [SRC_W-1:0]     last_idx;

    assign clr = rst | flush;

    rr_multi_picker #(
        .NUM_REQ   (NUM_REQ),
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .full      (slot_full),
        .rr_ptr    (rr_ptr),
        .port_oh   (port_oh),
        .port_vld  (port_vld),
        .port_idx  (port_idx),
        .grant     (grant),
        .any_grant (any_grant),
        .last_idx  (last_idx)
    );

    // A slot being granted this cycle is vacated at the edge, so it may be
    // refilled at that same edge; this makes grant -> ready combinational.
    assign req_ready = clr ? '0 : (~slot_full | grant);
    assign xfer      = req_valid & req_ready;

    // Payload storage needs no reset: slot_full qualifies every use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer[i]) begin
                slot[i] <= req_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            slot_full <= '0;
            rr_ptr    <= '0;
            cdb_valid <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cdb_data[p] <= '0;
                cdb_src[p]  <= '0;
            end
        end else begin
            // A tag-0 offer is consumed but leaves the slot empty, so it is never broadcast.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer[i]) begin
                    slot_full[i] <= (req_data[i].tag != '0);
                end else if (grant[i]) begin
                    slot_full[i] <= 1'b0;
                end
            end

            for (int p = 0; p < NUM_PORTS; p++) begin
                cdb_valid[p] <= port_vld[p];
                if (port_vld[p]) begin
                    cdb_data[p] <= slot[port_idx[p]];
                    cdb_src[p]  <= port_idx[p];
                end
            end

            // Resume the scan just past the last winner so every full slot
            // is reached within ceil(NUM_REQ/NUM_PORTS) cycles.
            if (any_grant) begin
                if (last_idx == SRC_W'(NUM_REQ - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= last_idx + 1'b1;
                end
            end
        end
    end

    a_grant_full: assert property (@(posedge clk) disable iff (rst)
        (grant & ~slot_full) == '0);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chk
        a_tag_nz: assert property (@(posedge clk) disable iff (rst)
            cdb_valid[p] |-> (cdb_data[p].tag != '0));
        a_onehot: assert property (@(posedge clk) disable iff (rst)
            $onehot0(port_oh[p]) && (port_vld[p] == (|port_oh[p])));
        for (genvar q = p + 1; q < NUM_PORTS; q++) begin : g_pair
            a_disjoint: assert property (@(posedge clk) disable iff (rst)
                (port_oh[p] & port_oh[q]) == '0);
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single, contention, wrap, refill, flush.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: req_ready checked combinationally before the loading edge.
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int NR = 8;
    localparam int NP = 2;

    logic          clk;
    logic          rst;
    logic          flush;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    cdb_entry_t    req_data [NR];
    logic [NP-1:0] cdb_valid;
    cdb_entry_t    cdb_data [NP];
    logic [2:0]    cdb_src  [NP];

    int n_chk = 0;
    int n_bad = 0;
    int seen [8];

    cdb_arbiter #(
        .NUM_REQ   (NR),
        .NUM_PORTS (NP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic cdb_entry_t mk(input logic [2:0] t, input logic [31:0] v);
        cdb_entry_t e;
        e         = '0;
        e.tag     = t;
        e.val     = v;
        e.is_br   = v[0];
        e.pc_next = v + 32'd4;
        return e;
    endfunction

    task automatic observe();
        for (int p = 0; p < NP; p++) begin
            if (cdb_valid[p] === 1'b1) begin
                seen[int'(cdb_data[p].tag)]++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        observe();
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 8; i++) seen[i] = 0;
    endtask

    task automatic idle();
        req_valid = '0;
        for (int i = 0; i < NR; i++) req_data[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        flush = 1'b0;
        clear_seen();

        // 1: reset with every source offering
        rst       = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NR; i++) req_data[i] = mk(3'(i % 7 + 1), 32'(i));
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        tick();
        tick();
        check("rst_cdb_valid", 32'(cdb_valid), 32'h0);
        check("rst_rr_ptr", 32'(dut.rr_ptr), 32'h0);
        rst = 1'b0;
        idle();
        #1;
        check("rst_ready_after", 32'(req_ready), 32'hFF);
        tick();
        check("rst_dropped", 32'(cdb_valid), 32'h0);

        // 2: single source
        req_valid   = 8'h08;
        req_data[3] = mk(3'd5, 32'h1234);
        tick();
        check("single_early", 32'(cdb_valid), 32'h0);
        idle();
        tick();
        check("single_valid", 32'(cdb_valid), 32'h1);
        check("single_tag", 32'(cdb_data[0].tag), 32'h5);
        check("single_val", cdb_data[0].val, 32'h1234);
        check("single_pc", cdb_data[0].pc_next, 32'h1238);
        check("single_src", 32'(cdb_src[0]), 32'h3);
        check("single_rr", 32'(dut.rr_ptr), 32'h4);
        tick();
        check("single_pulse", 32'(cdb_valid), 32'h0);

        // 3: contention, pointer at 0
        do_reset();
        clear_seen();
        req_valid   = 8'b0100_0111;
        req_data[0] = mk(3'd1, 32'h10);
        req_data[1] = mk(3'd2, 32'h20);
        req_data[2] = mk(3'd3, 32'h30);
        req_data[6] = mk(3'd4, 32'h60);
        tick();
        idle();
        #1;
        check("cont_ready", 32'(req_ready), 32'hBB);
        tick();
        check("cont1_valid", 32'(cdb_valid), 32'h3);
        check("cont1_src0", 32'(cdb_src[0]), 32'h0);
        check("cont1_src1", 32'(cdb_src[1]), 32'h1);
        check("cont1_tag0", 32'(cdb_data[0].tag), 32'h1);
        check("cont1_tag1", 32'(cdb_data[1].tag), 32'h2);
        check("cont1_rr", 32'(dut.rr_ptr), 32'h2);
        tick();
        check("cont2_valid", 32'(cdb_valid), 32'h3);
        check("cont2_src0", 32'(cdb_src[0]), 32'h2);
        check("cont2_src1", 32'(cdb_src[1]), 32'h6);
        check("cont2_val1", cdb_data[1].val, 32'h60);
        check("cont2_rr", 32'(dut.rr_ptr), 32'h7);
        tick();
        check("cont_drain", 32'(cdb_valid), 32'h0);
        for (int t = 1; t <= 4; t++) check($sformatf("cont_once_tag%0d", t), 32'(seen[t]), 32'h1);

        // 4: wrap from 7 to 0
        req_valid   = 8'h81;
        req_data[7] = mk(3'd6, 32'h70);
        req_data[0] = mk(3'd7, 32'h80);
        tick();
        idle();
        tick();
        check("wrap_valid", 32'(cdb_valid), 32'h3);
        check("wrap_src0", 32'(cdb_src[0]), 32'h7);
        check("wrap_src1", 32'(cdb_src[1]), 32'h0);
        check("wrap_tag0", 32'(cdb_data[0].tag), 32'h6);
        check("wrap_tag1", 32'(cdb_data[1].tag), 32'h7);
        check("wrap_rr", 32'(dut.rr_ptr), 32'h1);

        // 5: same-cycle refill on source 4, then a tag-0 offer
        clear_seen();
        req_valid   = 8'h10;
        req_data[4] = mk(3'd1, 32'h100);
        #1;
        check("refill_ready0", 32'(req_ready[4]), 32'h1);
        tick();
        req_data[4] = mk(3'd2, 32'h200);
        #1;
        check("refill_ready1", 32'(req_ready[4]), 32'h1);
        tick();
        check("refill1_valid", 32'(cdb_valid), 32'h1);
        check("refill1_tag", 32'(cdb_data[0].tag), 32'h1);
        check("refill1_src", 32'(cdb_src[0]), 32'h4);
        req_data[4] = mk(3'd3, 32'h300);
        #1;
        check("refill_ready2", 32'(req_ready[4]), 32'h1);
        tick();
        check("refill2_valid", 32'(cdb_valid), 32'h1);
        check("refill2_tag", 32'(cdb_data[0].tag), 32'h2);
        req_data[4] = mk(3'd0, 32'hDEAD);
        #1;
        check("refill_ready3", 32'(req_ready[4]), 32'h1);
        tick();
        check("refill3_tag", 32'(cdb_data[0].tag), 32'h3);
        check("refill3_val", cdb_data[0].val, 32'h300);
        idle();
        tick();
        check("refill_tag0_none", 32'(cdb_valid), 32'h0);
        tick();
        check("refill_idle", 32'(cdb_valid), 32'h0);
        check("refill_seen0", 32'(seen[0]), 32'h0);
        check("refill_seen3", 32'(seen[3]), 32'h1);

        // 6: flush with five slots loaded and one grant already out
        do_reset();
        req_valid   = 8'b1011_1010;
        req_data[1] = mk(3'd1, 32'h11);
        req_data[3] = mk(3'd2, 32'h33);
        req_data[4] = mk(3'd3, 32'h44);
        req_data[5] = mk(3'd4, 32'h55);
        req_data[7] = mk(3'd5, 32'h77);
        tick();
        idle();
        tick();
        check("flush_pre_valid", 32'(cdb_valid), 32'h3);
        check("flush_pre_src1", 32'(cdb_src[1]), 32'h3);
        flush       = 1'b1;
        req_valid   = 8'h04;
        req_data[2] = mk(3'd6, 32'h22);
        #1;
        check("flush_ready", 32'(req_ready), 32'h0);
        tick();
        check("flush_valid", 32'(cdb_valid), 32'h0);
        check("flush_rr", 32'(dut.rr_ptr), 32'h0);
        flush = 1'b0;
        idle();
        clear_seen();
        tick();
        tick();
        tick();
        check("flush_quiet", 32'(cdb_valid), 32'h0);
        req_valid   = 8'h40;
        req_data[6] = mk(3'd7, 32'h66);
        tick();
        idle();
        tick();
        check("post_valid", 32'(cdb_valid), 32'h1);
        check("post_src", 32'(cdb_src[0]), 32'h6);
        check("post_tag", 32'(cdb_data[0].tag), 32'h7);
        tick();
        check("post_stale", 32'(seen[3] + seen[4] + seen[5] + seen[6]), 32'h0);
        check("post_once", 32'(seen[7]), 32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
